// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that grants one requester at a time and drives a shared
// transparent-latch bank with a fixed setup / gate pulse / hold sequence.
module latch_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [WIDTH-1:0]         D,
  output logic                     G,
  output logic                     busy
);

  localparam int SP   = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int CMAX = (SP > HOLD) ? SP : HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_GATE, S_HOLD, S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     last_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [WIDTH-1:0]  d_q;
  logic              g_q;
  logic              busy_q;

  logic              found_d;
  logic [IW-1:0]     win_d;
  int                cand;

  // Search starts just after the last winner and wraps, so a continuous
  // requester cannot win twice in one rotation while others wait.
  always_comb begin
    found_d = 1'b0;
    win_d   = last_q;
    cand    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found_d && req[IW'(cand)]) begin
        found_d = 1'b1;
        win_d   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      d_q     <= '0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
            d_q     <= wdata[win_d*WIDTH +: WIDTH];
            last_q  <= win_d;
            cnt_q   <= CW'(SETUP);
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == CW'(1)) begin
            g_q     <= 1'b1;
            cnt_q   <= CW'(PULSE);
            state_q <= S_GATE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_GATE: begin
          if (cnt_q == CW'(1)) begin
            g_q     <= 1'b0;
            cnt_q   <= CW'(HOLD);
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == CW'(1)) begin
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign D    = d_q;
  assign G    = g_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: two instances (default and overridden timing)
// compared every cycle against a timeline model of each transaction.
module tb_latch_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req,  req2;
  logic [31:0] wdata;
  logic [15:0] wdata2;
  logic [3:0]  gnt, done, gnt2, done2;
  logic [7:0]  D;
  logic [3:0]  D2;
  logic        G, busy, G2, busy2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  latch_write_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .done(done), .D(D), .G(G), .busy(busy)
  );

  latch_write_arbiter #(.N_REQ(4), .WIDTH(4), .SETUP(2), .PULSE(1), .HOLD(3)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wdata(wdata2),
    .gnt(gnt2), .done(done2), .D(D2), .G(G2), .busy(busy2)
  );

  // Model: per instance, whether a transaction is active, cycles since its
  // grant edge, the winner, the round-robin pointer and the captured data.
  int         m_act [2];
  int         m_t   [2];
  int         m_win [2];
  int         m_ptr [2];
  logic [7:0] m_d   [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_t[k] = 0; m_win[k] = 0; m_ptr[k] = 3; m_d[k] = '0;
    end
  endtask

  task automatic step(int k, logic [3:0] r, logic [31:0] wd, int w, int s, int p, int h);
    int c;
    bit found;
    if (m_act[k] == 0) begin
      found = 0;
      for (int i = 1; i <= 4; i++) begin
        c = (m_ptr[k] + i) % 4;
        if (!found && r[c]) begin
          found = 1;
          m_win[k] = c;
        end
      end
      if (found) begin
        m_act[k] = 1;
        m_t[k]   = 0;
        m_ptr[k] = m_win[k];
        m_d[k]   = 8'((wd >> (m_win[k] * w)) & ((32'd1 << w) - 1));
      end
    end else if (m_t[k] == s + p + h) begin
      m_act[k] = 0;
    end else begin
      m_t[k]++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      step(0, req,  wdata,           8, 1, 2, 1);
      step(1, req2, {16'b0, wdata2}, 4, 2, 1, 3);
    end
  end

  task automatic check_inst(int k, int s, int p, int h,
                            logic [3:0] g_gnt, logic [3:0] g_done,
                            logic [7:0] g_d, logic g_g, logic g_busy);
    logic [3:0] e_gnt, e_done;
    logic       e_g;
    e_gnt  = (m_act[k] != 0) ? 4'(1 << m_win[k]) : 4'd0;
    e_done = (m_act[k] != 0 && m_t[k] == s + p + h) ? 4'(1 << m_win[k]) : 4'd0;
    e_g    = (m_act[k] != 0 && m_t[k] >= s && m_t[k] < s + p);
    chk($sformatf("u%0d_gnt", k),  {28'b0, g_gnt},  {28'b0, e_gnt});
    chk($sformatf("u%0d_done", k), {28'b0, g_done}, {28'b0, e_done});
    chk($sformatf("u%0d_D", k),    {24'b0, g_d},    {24'b0, m_d[k]});
    chk($sformatf("u%0d_G", k),    {31'b0, g_g},    {31'b0, e_g});
    chk($sformatf("u%0d_busy", k), {31'b0, g_busy}, {31'b0, 1'(m_act[k] != 0)});
  endtask

  task automatic tick();
    @(negedge clk);
    check_inst(0, 1, 2, 1, gnt,  done,  D,            G,  busy);
    check_inst(1, 2, 1, 3, gnt2, done2, {4'b0, D2},   G2, busy2);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; req = '0; req2 = '0; wdata = '0; wdata2 = '0;
    repeat (2) tick();
    rst = 1'b0;

    // single write from requester 1; dut2 gets two steady requesters
    wdata = {8'h11, 8'h22, 8'hA5, 8'h44};
    req = 4'b0010; req2 = 4'b0101; wdata2 = 16'h9C3B;
    tick();
    req = '0; wdata = $urandom;
    repeat (8) tick();

    // everyone requests, data shuffled every cycle
    req = 4'b1111;
    repeat (32) begin tick(); wdata = $urandom; wdata2 = 16'($urandom); end
    req = '0;
    repeat (8) tick();

    // wrap-around: 3 must win after 0 even though 0 keeps requesting
    req = 4'b0001;
    tick();
    req = 4'b1001;
    repeat (16) tick();
    req = '0;
    repeat (8) tick();

    // one-cycle request, data changes after grant
    req = 4'b0100; wdata = 32'h00C30000;
    tick();
    req = '0; wdata = 32'h00FF0000;
    repeat (8) tick();

    // random traffic
    repeat (300) begin
      tick();
      req = 4'($urandom); wdata = $urandom;
      req2 = 4'($urandom); wdata2 = 16'($urandom);
    end
    req = '0; req2 = '0;
    repeat (10) tick();

    // reset while the gate is open
    req = 4'b0100; wdata = 32'h005A0000;
    for (int i = 0; i < 20 && !G; i++) tick();
    if (!G) chk("wait_gate", {31'b0, G}, 32'd1);
    req = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_G",    {31'b0, G},    32'd0);
    chk("rst_D",    {24'b0, D},    32'd0);
    chk("rst_gnt",  {28'b0, gnt},  32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {28'b0, done}, 32'd0);
    tick();
    rst = 1'b0; req = 4'b1000; wdata = 32'h7E000000;
    tick();
    chk("post_rst_gnt", {28'b0, gnt}, 32'h8);
    req = '0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Round-robin arbiter and write sequencer for a shared bank of transparent D latches. Up to N_REQ requesters contend for write access. The block grants one requester at a time and captures its data. It then drives the shared latch data bus (D) and gate (G) with a fixed setup/pulse/hold sequence, so D never changes while G is high or within the guard windows around it. It sits between requester logic and the latch bank, and is the only driver of the bank's D and G.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, latch bank data width
- SETUP, 1, cycles D is stable before G rises (≥1)
- PULSE, 2, cycles G is high (≥1)
- HOLD, 1, cycles D is held after G falls (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  write request per requester, level
- wdata  in  N_REQ*WIDTH  requester data; slice i = wdata[i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, high from grant through DONE
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- D  out  WIDTH  data to latch bank
- G  out  1  latch gate
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has five states: IDLE, SETUP, GATE, HOLD, DONE. All outputs are registered.
- IDLE: if any req bit is high, select the winner by round-robin.
  - At the next edge: gnt is set one-hot to the winner, D is loaded from the winner's wdata slice, the cycle counter is loaded, and the FSM moves to SETUP.
- SETUP: G=0, D stable, lasts SETUP cycles, then GATE.
- GATE: G=1, D stable, lasts PULSE cycles, then HOLD.
- HOLD: G=0, D stable, lasts HOLD cycles, then DONE.
- DONE: lasts one cycle. done[winner]=1, G=0, gnt still asserted, D still held. Then IDLE with gnt=0 and done=0.
- D holds its last value in IDLE. It changes only on a grant edge.
- Round-robin pointer:
  - Search starts at (last_winner+1) mod N_REQ and wraps from N_REQ-1 to 0.
  - After reset, requester 0 has the highest priority.
  - The pointer updates only on a grant.
- wdata is captured at the grant edge. Requesters may change wdata or drop req afterwards.
- A transaction always runs to completion once granted, even if req drops. done is still pulsed.
- req arriving or changing during non-IDLE states is ignored until the next IDLE cycle.
- A requester holding req continuously gets at most one grant per rotation while others request.
- Counter width is $clog2(max(SETUP,PULSE,HOLD)+1). The counter decrements and changes state at 1.

## Timing
- Reset (async, immediate): G=0, D=0, gnt=0, done=0, busy=0, FSM=IDLE, pointer so that requester 0 has top priority.
  - Reset mid-transaction aborts it: G drops without waiting for a clock, and no done is issued.
- Grant latency is 1 cycle: req seen high in IDLE at edge t0 gives gnt/busy/D valid after t0.
- Taking t0 as the grant edge:
  - G rises at edge t0+SETUP and falls at edge t0+SETUP+PULSE.
  - done is high in cycle [t0+SETUP+PULSE+HOLD, +1).
  - busy and gnt fall at edge t0+SETUP+PULSE+HOLD+1.
- A mandatory IDLE cycle follows DONE. Back-to-back grants are SETUP+PULSE+HOLD+2 edges apart: 6 with defaults.
- G is never high in two consecutive transactions without at least SETUP+HOLD+2 low cycles between them.
- Invariant: gnt has at most one bit set, and gnt is nonzero exactly when busy is high.

## Test plan
- Single write, defaults: req=4'b0010, wdata slice1=8'hA5 → gnt=4'b0010 one cycle later, D=8'hA5, G high for exactly 2 cycles after 1 setup cycle, done[1] one cycle after 1 hold cycle. Total 5 busy cycles.
- All request simultaneously (req=4'b1111, held) → grants in order 0,1,2,3,0, each 6 cycles apart. D matches each slice and never changes while G=1.
- Wrap-around fairness: req0 held high, req3 pulsed after grant to 0 → next grant goes to 3, not 0; then 0.
- Request withdrawn: req2 asserted one cycle then dropped → full sequence still runs, done[2] pulses, and a new wdata value presented after the grant does not appear on D.
- Reset in GATE: assert rst while G=1 → G, D, gnt, busy go to 0 immediately without a clock. No done. After release with req=4'b1000 → grant to 3 (pointer reset, 0..2 idle).
- Parameter override SETUP=2, PULSE=1, HOLD=3, WIDTH=4 → G high for 1 cycle starting 2 cycles after grant, done 3 cycles after G falls, back-to-back grant spacing 8 edges.
